// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus master/slave ports.
//   - bus_state_e : transaction state encoding used by both ports
//   - DEF_*       : default address/data widths and handshake timeout
//   - cnt_width   : width of a bit counter able to index the longer field
package bus_pkg;

   localparam int DEF_ADDR_WIDTH = 12;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_TIMEOUT    = 64;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_ADDR  = 3'd2,
      ST_WDATA = 3'd3,
      ST_RWAIT = 3'd4,
      ST_RDATA = 3'd5,
      ST_DONE  = 3'd6
   } bus_state_e;

   // One counter serves both the address and the data phase, so it is sized
   // for the longer of the two; never narrower than one bit.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register, MSB first.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   load       : capture par_in (has priority over shift)
//   shift      : move the register one place towards the MSB, filling with 0
//   par_in     : parallel word
//   ser_out    : current MSB
module piso_shift #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] par_in,
   output logic             ser_out
);

   logic [WIDTH-1:0] sreg_q, sreg_d;

   always_comb begin
      sreg_d = sreg_q;
      if (load)
         sreg_d = par_in;
      else if (shift)
         sreg_d = sreg_q << 1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sreg_q <= '0;
      else
         sreg_q <= sreg_d;
   end

   assign ser_out = sreg_q[WIDTH-1];

endmodule

// File: rtl/master_port.sv
// Serial bus master port. Accepts one local read/write request at a time,
// runs the REQ handshake, serializes the address (and write data) MSB first,
// collects serial read data, and reports completion with a one-cycle pulse.
//   clk, reset                : clock, asynchronous active-high reset
//   req_valid/req_ready       : local request handshake (req_write/addr/wdata)
//   rsp_valid/rsp_rdata/rsp_err : completion pulse, read data, timeout flag
//   read_en/write_en          : bus command to the slave
//   master_valid/master_ready : master side of the bus handshake
//   slave_ready/slave_valid   : slave side of the bus handshake
//   tx_address/tx_data        : serial address / write data out
//   rx_data                   : serial read data in
module master_port
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  read_en,
   output logic                  write_en,
   output logic                  master_valid,
   output logic                  master_ready,
   input  logic                  slave_ready,
   input  logic                  slave_valid,
   output logic                  tx_address,
   output logic                  tx_data,
   input  logic                  rx_data
);

   localparam int CNT_W = cnt_width(ADDR_WIDTH, DATA_WIDTH);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_WIDTH - 1);
   // RDATA only shifts the bits after the MSB captured in RWAIT
   localparam logic [CNT_W-1:0] RDATA_LAST = CNT_W'((DATA_WIDTH > 1) ? DATA_WIDTH - 2 : 0);
   localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);

   bus_state_e            state_q, state_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic                  wr_q, wr_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic accept;
   logic addr_ser, data_ser;
   logic in_cmd;

   assign accept = req_valid & req_ready;

   // Address and write data are latched straight into their shifters at
   // acceptance, so later changes on req_* cannot leak into the transfer.
   piso_shift #(.WIDTH(ADDR_WIDTH)) u_addr_piso (
      .clk     (clk),
      .reset   (reset),
      .load    (accept),
      .shift   (state_q == ST_ADDR),
      .par_in  (req_addr),
      .ser_out (addr_ser)
   );

   piso_shift #(.WIDTH(DATA_WIDTH)) u_data_piso (
      .clk     (clk),
      .reset   (reset),
      .load    (accept),
      .shift   (state_q == ST_WDATA),
      .par_in  (req_wdata),
      .ser_out (data_ser)
   );

   // Next state and datapath
   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      err_d   = err_q;
      rdata_d = rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_REQ;
               wr_d    = req_write;
               err_d   = 1'b0;
               rdata_d = '0;
            end
         end
         ST_REQ: begin
            // a ready on the last allowed cycle still wins over the timeout
            if (slave_ready)
               state_d = ST_ADDR;
            else if (tmo_q == TMO_LAST) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end
         end
         ST_ADDR: begin
            if (bit_cnt_q == ADDR_LAST)
               state_d = wr_q ? ST_WDATA : ST_RWAIT;
         end
         ST_WDATA: begin
            if (bit_cnt_q == DATA_LAST)
               state_d = ST_DONE;
         end
         ST_RWAIT: begin
            if (slave_valid) begin
               rdata_d = (rdata_q << 1) | DATA_WIDTH'(rx_data);
               state_d = (DATA_WIDTH == 1) ? ST_DONE : ST_RDATA;
            end else if (tmo_q == TMO_LAST) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end
         end
         ST_RDATA: begin
            rdata_d = (rdata_q << 1) | DATA_WIDTH'(rx_data);
            if (bit_cnt_q == RDATA_LAST)
               state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // bit counter restarts on every state change
      if (state_d != state_q)
         bit_cnt_d = '0;
      else if (state_q == ST_ADDR || state_q == ST_WDATA || state_q == ST_RDATA)
         bit_cnt_d = bit_cnt_q + CNT_W'(1);
      else
         bit_cnt_d = '0;

      // timeout counter holds 0 outside the waiting states, so it is clear
      // on entry to REQ and RWAIT
      if ((state_q == ST_REQ || state_q == ST_RWAIT) && state_d == state_q)
         tmo_d = tmo_q + TMO_W'(1);
      else
         tmo_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         tmo_q     <= '0;
         wr_q      <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         tmo_q     <= tmo_d;
         wr_q      <= wr_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   // Outputs are decoded from registered state only; reset clears the state
   // asynchronously, so they drop in the same cycle reset rises.
   always_comb begin
      in_cmd = (state_q == ST_REQ)   || (state_q == ST_ADDR)  ||
               (state_q == ST_WDATA) || (state_q == ST_RWAIT) ||
               (state_q == ST_RDATA);

      req_ready    = (state_q == ST_IDLE) & ~reset;
      master_valid = in_cmd;
      write_en     = in_cmd & wr_q;
      read_en      = in_cmd & ~wr_q;
      master_ready = (state_q == ST_RWAIT) || (state_q == ST_RDATA);
      tx_address   = (state_q == ST_ADDR)  & addr_ser;
      tx_data      = (state_q == ST_WDATA) & data_ser;
      rsp_valid    = (state_q == ST_DONE);
      rsp_err      = (state_q == ST_DONE) & err_q;
      rsp_rdata    = (state_q == ST_DONE && !wr_q && !err_q) ? rdata_q : '0;
   end

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port (default 12-bit address, 8-bit data,
// timeout 64). Cycle 0 is the cycle in which the request is presented;
// outputs are sampled on the falling edge and inputs driven right after.
module tb_master_port;

   localparam int AW = 12;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic          read_en, write_en, master_valid, master_ready;
   logic          slave_ready, slave_valid;
   logic          tx_address, tx_data, rx_data;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(64)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .read_en      (read_en),
      .write_en     (write_en),
      .master_valid (master_valid),
      .master_ready (master_ready),
      .slave_ready  (slave_ready),
      .slave_valid  (slave_valid),
      .tx_address   (tx_address),
      .tx_data      (tx_data),
      .rx_data      (rx_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [16:0] all_outs();
      return {req_ready, rsp_valid, rsp_rdata, rsp_err, read_en, write_en,
              master_valid, master_ready, tx_address, tx_data};
   endfunction

   // Presents one request at cycle 0 and plays a scripted slave:
   // slave_ready from rdy_cyc on, slave_valid at vld_cyc with rx_word
   // following MSB first. hold keeps req_valid high with junk req fields.
   task automatic run_txn(input string name, input logic wr,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int rdy_cyc, input int vld_cyc,
                          input logic [DW-1:0] rx_word, input bit hold,
                          input int exp_done, input bit exp_err,
                          input logic [DW-1:0] exp_rdata);
      int a0, d0, rsp_cyc, rsp_cnt;
      logic [AW-1:0] abits;
      logic [DW-1:0] dbits, rd;
      logic astray, dstray, mrdy, er;
      logic [2:0] cmd1;
      logic [5:0] bus;
      a0 = rdy_cyc + 1;
      d0 = a0 + AW;
      rsp_cyc = -1; rsp_cnt = 0;
      abits = '0; dbits = '0; rd = '0; er = 1'b0;
      astray = 1'b0; dstray = 1'b0; mrdy = 1'b0; cmd1 = '0; bus = '0;

      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
      slave_ready = 1'b0; slave_valid = 1'b0; rx_data = 1'b0;

      for (int k = 1; k <= exp_done; k++) begin
         @(negedge clk);
         if (k == 1) cmd1 = {master_valid, write_en, read_en};
         if (k >= a0 && k < a0 + AW) abits = {abits[AW-2:0], tx_address};
         else astray |= tx_address;
         if (wr && k >= d0 && k < d0 + DW) dbits = {dbits[DW-2:0], tx_data};
         else dstray |= tx_data;
         if (k == vld_cyc) mrdy = master_ready;
         if (rsp_valid) begin
            rsp_cnt++;
            if (rsp_cyc < 0) begin
               rsp_cyc = k; rd = rsp_rdata; er = rsp_err;
               bus = {master_valid, master_ready, read_en, write_en, tx_address, tx_data};
            end
         end
         if (hold) begin
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
         end else
            req_valid = 1'b0;
         slave_ready = (k >= rdy_cyc);
         slave_valid = (k == vld_cyc);
         rx_data = (k >= vld_cyc && k < vld_cyc + DW) ? rx_word[DW-1-(k-vld_cyc)] : 1'b0;
      end
      slave_ready = 1'b0; slave_valid = 1'b0; rx_data = 1'b0;

      check({name, " done_cycle"}, rsp_cyc, exp_done);
      check({name, " rsp_pulses"}, rsp_cnt, 1);
      check({name, " rsp_err"}, er, exp_err);
      check({name, " rsp_rdata"}, rd, exp_rdata);
      check({name, " bus_at_done"}, bus, 0);
      check({name, " cmd_in_req"}, cmd1, {1'b1, wr, ~wr});
      check({name, " tx_addr_stray"}, astray, 0);
      check({name, " tx_data_stray"}, dstray, 0);
      if (rdy_cyc < exp_done) check({name, " tx_address"}, abits, addr);
      if (wr && rdy_cyc < exp_done) check({name, " tx_data"}, dbits, wdata);
      if (vld_cyc < exp_done) check({name, " master_ready"}, mrdy, 1);
      if (!hold) begin
         @(negedge clk);
         check({name, " rsp_one_cycle"}, rsp_valid, 0);
         check({name, " idle_ready"}, req_ready, 1);
      end
   endtask

   initial begin
      int pulses, mvs;
      reset = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      slave_ready = 1'b0; slave_valid = 1'b0; rx_data = 1'b0;

      repeat (2) @(negedge clk);
      check("reset outs", all_outs(), 17'h0);
      reset = 1'b0;
      @(negedge clk);
      check("post-reset outs", all_outs(), 17'h10000);

      // write 0xA5 to 0x123, ready immediately: DONE at 22
      run_txn("wr_a5", 1'b1, 12'h123, 8'hA5, 1, 1000, 8'h00, 1'b0, 22, 1'b0, 8'h00);
      // write with slave_ready arriving at cycle 4: DONE at 25
      run_txn("wr_late", 1'b1, 12'hFFF, 8'h01, 4, 1000, 8'h00, 1'b0, 25, 1'b0, 8'h00);
      // read 0x001, slave_valid 3 cycles after ADDR (cycle 16): DONE at 24
      run_txn("rd_3c", 1'b0, 12'h001, 8'hFF, 1, 16, 8'h3C, 1'b0, 24, 1'b0, 8'h3C);
      // no slave_ready: 64 REQ cycles then DONE at 65 with error
      run_txn("tmo_req", 1'b1, 12'h456, 8'h77, 1000, 1000, 8'h00, 1'b0, 65, 1'b1, 8'h00);
      // request after timeout proceeds normally
      run_txn("wr_after_tmo", 1'b1, 12'h800, 8'h5A, 1, 1000, 8'h00, 1'b0, 22, 1'b0, 8'h00);
      // ready on the last allowed REQ cycle is still honoured
      run_txn("rdy_edge", 1'b1, 12'hA5A, 8'hC3, 64, 1000, 8'h00, 1'b0, 85, 1'b0, 8'h00);
      // read whose slave never answers: 64 RWAIT cycles from 14, DONE at 78
      run_txn("tmo_rwait", 1'b0, 12'h0F0, 8'h00, 1, 1000, 8'h00, 1'b0, 78, 1'b1, 8'h00);

      // reset during the 5th ADDR cycle (cycle 6)
      req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h123; req_wdata = 8'hA5;
      slave_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      check("mid_rst pre", master_valid, 1);
      reset = 1'b1;
      #1;
      check("mid_rst outs", all_outs(), 17'h0);
      @(negedge clk);
      reset = 1'b0;
      slave_ready = 1'b0;
      pulses = 0; mvs = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (rsp_valid) pulses++;
         if (master_valid) mvs++;
      end
      check("mid_rst rsp_pulses", pulses, 0);
      check("mid_rst bus_idle", mvs, 0);
      check("mid_rst ready", req_ready, 1);
      run_txn("wr_after_rst", 1'b1, 12'h3C3, 8'h96, 1, 1000, 8'h00, 1'b0, 22, 1'b0, 8'h00);

      // req_valid held high with changing req fields, back-to-back writes
      run_txn("b2b_0", 1'b1, 12'h5A3, 8'h3C, 1, 1000, 8'h00, 1'b1, 22, 1'b0, 8'h00);
      @(negedge clk);
      check("b2b gap rsp", rsp_valid, 0);
      check("b2b gap ready", req_ready, 1);
      run_txn("b2b_1", 1'b1, 12'h0F0, 8'h81, 1, 1000, 8'h00, 1'b0, 22, 1'b0, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
